complex_vec_loader: RTL and testbench

COMPLEX_VEC_LOADER -- requirements
Module: complex_vec_loader

---
 rtl/complex_vec_loader_if.sv | 29 ++
 rtl/complex_vec_loader.sv | 101 ++++++++++
 tb/tb_complex_vec_loader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/complex_vec_loader_if.sv
// Handshake and bus signals between the vector loader, its upstream source and the dot-product engine.
interface complex_vec_loader_if #(
    parameter int unsigned SIZE = 16
);
    localparam int unsigned CW = $clog2(SIZE) + 1;

    logic [3:0][63:0]        elem_i;
    logic                    last_i;
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic                    flush_i;
    logic [SIZE*4-1:0][63:0] operands_o;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [CW-1:0]           count_o;
    logic                    busy_o;

    // The loader itself.
    modport slave (
        input  elem_i, last_i, in_valid_i, flush_i, out_ready_i,
        output in_ready_o, operands_o, out_valid_o, count_o, busy_o
    );

    // The environment: upstream source plus downstream engine.
    modport master (
        output elem_i, last_i, in_valid_i, flush_i, out_ready_i,
        input  in_ready_o, operands_o, out_valid_o, count_o, busy_o
    );
endinterface

// File: rtl/complex_vec_loader.sv
// Collects complex element pairs into a zero-padded operand vector for the dot-product engine.
// Optional macro COMPLEX_VEC_LOADER_CONJ_EN conjugates operand 2 (sign of b2 flipped on write).
module complex_vec_loader #(
    parameter int unsigned SIZE = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    complex_vec_loader_if.slave bus
);
    localparam int unsigned CW = $clog2(SIZE) + 1;
    localparam int unsigned IW = $clog2(SIZE);

    typedef enum logic {FILL = 1'b0, ISSUE = 1'b1} state_t;
    typedef logic [SIZE-1:0][3:0][63:0] slots_t;

    state_t           state_q, state_d;
    slots_t           slots_q, slots_d;
    logic [CW-1:0]    count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [3:0][63:0] pair;
    logic [IW-1:0]    idx;
    logic             accept;
    logic             out_fire;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, slot writes and registered-output targets.
    always_comb begin
        state_d  = state_q;
        slots_d  = slots_q;
        count_d  = count_q;
        pair     = bus.elem_i;
        idx      = count_q[IW-1:0];
        accept   = (state_q == FILL) && in_ready_q && bus.in_valid_i;
        out_fire = (state_q == ISSUE) && out_valid_q && bus.out_ready_i;
`ifdef COMPLEX_VEC_LOADER_CONJ_EN
        pair[3][63] = ~bus.elem_i[3][63];
`endif
        if (bus.flush_i) begin
            // Flush wins over any same-cycle handshake.
            state_d = FILL;
            slots_d = '0;
            count_d = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        slots_d[idx] = pair;
                        count_d      = CW'(count_q + CW'(1));
                        if (bus.last_i || (count_q == CW'(SIZE - 1))) begin
                            state_d = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (out_fire) begin
                        state_d = FILL;
                        slots_d = '0;
                        count_d = '0;
                    end
                end
                default: state_d = FILL;
            endcase
        end
        in_ready_d  = (state_d == FILL);
        out_valid_d = (state_d == ISSUE);
        busy_d      = (count_d != '0) || out_valid_d;
    end

    // Datapath and output registers; in_ready stays low while reset is held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slots_q     <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            slots_q     <= slots_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.operands_o  = slots_q;
    assign bus.count_o     = count_q;
    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_complex_vec_loader.sv
// Directed scoreboard bench for complex_vec_loader (default SIZE=16).
module tb_complex_vec_loader;
    localparam int unsigned SIZE = 16;
    localparam int unsigned CW   = $clog2(SIZE) + 1;

    typedef logic [SIZE*4-1:0][63:0] vec_t;
    typedef struct {
        vec_t          ops;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t cur;
    int unsigned ncur;
    vec_t held;

    always #5 clk_i = ~clk_i;

    complex_vec_loader_if #(.SIZE(SIZE)) bus ();

    complex_vec_loader #(.SIZE(SIZE)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input vec_t obs, input vec_t exp);
        int first;
        first = 0;
        for (int i = SIZE*4-1; i >= 0; i--) begin
            if (obs[i] !== exp[i]) first = i;
        end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s word %0d observed=%h expected=%h", tag, first, obs[first], exp[first]);
        end
    endtask

    // Reference storage of one accepted pair.
    task automatic model_beat(input logic [3:0][63:0] e);
        for (int j = 0; j < 4; j++) cur[4*ncur + j] = e[j];
`ifdef COMPLEX_VEC_LOADER_CONJ_EN
        cur[4*ncur + 3][63] = ~e[3][63];
`endif
        ncur++;
    endtask

    task automatic model_push;
        exp_t x;
        x.ops = cur;
        x.cnt = CW'(ncur);
        sb.push_back(x);
        cur  = '0;
        ncur = 0;
    endtask

    task automatic drive(input logic [3:0][63:0] e, input logic last);
        bus.in_valid_i = 1'b1;
        bus.elem_i     = e;
        bus.last_i     = last;
    endtask

    task automatic idle_in;
        bus.in_valid_i = 1'b0;
        bus.last_i     = 1'b0;
        bus.elem_i     = '0;
    endtask

    // Bounded wait for out_valid, then pop and compare against the scoreboard.
    task automatic check_out(input string tag, output vec_t got);
        exp_t x;
        for (int i = 0; i < 20 && bus.out_valid_o !== 1'b1; i++) tick();
        got = bus.operands_o;
        chk({tag, "_valid"}, 64'(bus.out_valid_o), 64'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            x = sb.pop_front();
            chk_vec({tag, "_ops"}, bus.operands_o, x.ops);
            chk({tag, "_count"}, 64'(bus.count_o), 64'(x.cnt));
        end
    endtask

    task automatic release_out(input string tag);
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        chk({tag, "_in_ready"}, 64'(bus.in_ready_o), 64'd1);
        chk({tag, "_count0"}, 64'(bus.count_o), 64'd0);
        chk_vec({tag, "_ops0"}, bus.operands_o, '0);
        chk({tag, "_valid0"}, 64'(bus.out_valid_o), 64'd0);
    endtask

    initial begin
        logic [3:0][63:0] e;
        vec_t             got;
        logic [63:0]      b2_exp;

        cur  = '0;
        ncur = 0;
        rst_i = 1'b1;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b0;
        idle_in();

        // Reset state.
        repeat (3) tick();
        chk("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
        chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_count", 64'(bus.count_o), 64'd0);
        chk_vec("rst_ops", bus.operands_o, '0);
        rst_i = 1'b0;
        chk("rst_rel_pre", 64'(bus.in_ready_o), 64'd0);
        tick();
        chk("rst_rel_in_ready", 64'(bus.in_ready_o), 64'd1);

        // Full vector: pair k words = k, no last.
        for (int k = 0; k < SIZE; k++) begin
            for (int j = 0; j < 4; j++) e[j] = 64'(k);
            drive(e, 1'b0);
            model_beat(e);
            tick();
            if (k == SIZE - 2) begin
                chk("full_pre_valid", 64'(bus.out_valid_o), 64'd0);
                chk("full_pre_count", 64'(bus.count_o), 64'(SIZE - 1));
            end
        end
        model_push();
        idle_in();
        chk("full_latency", 64'(bus.out_valid_o), 64'd1);
        chk("full_in_ready", 64'(bus.in_ready_o), 64'd0);
        chk("full_busy", 64'(bus.busy_o), 64'd1);
        check_out("full", got);
        release_out("full_rel");
        chk("full_rel_busy", 64'(bus.busy_o), 64'd0);

        // Short vector; out_ready held high while filling has no effect.
        bus.out_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) e[j] = {$urandom(), $urandom()};
            drive(e, k == 2);
            model_beat(e);
            tick();
        end
        bus.out_ready_i = 1'b0;
        model_push();
        chk("short_latency", 64'(bus.out_valid_o), 64'd1);
        check_out("short", held);

        // Backpressure with a pending upstream beat.
        for (int j = 0; j < 4; j++) e[j] = 64'hDEAD_0000_0000_0000 | 64'(j);
        drive(e, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_vec("bp_ops_stable", bus.operands_o, held);
            chk("bp_in_ready", 64'(bus.in_ready_o), 64'd0);
            chk("bp_valid", 64'(bus.out_valid_o), 64'd1);
            chk("bp_count", 64'(bus.count_o), 64'd3);
        end
        release_out("bp_rel");
        idle_in();

        // Flush coincident with beat 7.
        for (int k = 0; k < 7; k++) begin
            for (int j = 0; j < 4; j++) e[j] = 64'(100 + 4*k + j);
            drive(e, 1'b0);
            model_beat(e);
            tick();
        end
        chk("fl_count7", 64'(bus.count_o), 64'd7);
        for (int j = 0; j < 4; j++) e[j] = 64'hF00D;
        drive(e, 1'b0);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        idle_in();
        cur  = '0;
        ncur = 0;
        chk("fl_count0", 64'(bus.count_o), 64'd0);
        chk_vec("fl_ops0", bus.operands_o, '0);
        chk("fl_valid", 64'(bus.out_valid_o), 64'd0);
        chk("fl_busy", 64'(bus.busy_o), 64'd0);
        repeat (3) tick();
        chk("fl_valid_later", 64'(bus.out_valid_o), 64'd0);

        // Conjugation of b2.
        e[0] = 64'h4000_0000_0000_0000;
        e[1] = 64'h4008_0000_0000_0000;
        e[2] = 64'hC010_0000_0000_0000;
        e[3] = 64'h3FF0_0000_0000_0000;
`ifdef COMPLEX_VEC_LOADER_CONJ_EN
        b2_exp = 64'hBFF0_0000_0000_0000;
`else
        b2_exp = 64'h3FF0_0000_0000_0000;
`endif
        drive(e, 1'b1);
        model_beat(e);
        tick();
        idle_in();
        model_push();
        chk("conj_b2", bus.operands_o[3], b2_exp);
        chk("conj_a1", bus.operands_o[0], 64'h4000_0000_0000_0000);
        check_out("conj", got);
        release_out("conj_rel");

        // Reset while in ISSUE drops the vector.
        for (int j = 0; j < 4; j++) e[j] = 64'(7 + j);
        drive(e, 1'b1);
        tick();
        idle_in();
        chk("rsti_pre_valid", 64'(bus.out_valid_o), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rsti_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rsti_busy", 64'(bus.busy_o), 64'd0);
        chk("rsti_in_ready", 64'(bus.in_ready_o), 64'd0);
        chk("rsti_count", 64'(bus.count_o), 64'd0);
        chk_vec("rsti_ops", bus.operands_o, '0);
        tick();
        rst_i = 1'b0;
        tick();
        chk("rsti_rel_in_ready", 64'(bus.in_ready_o), 64'd1);
        chk("rsti_rel_valid", 64'(bus.out_valid_o), 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
